// File: rtl/counter_pkg.sv
// Shared types for the modal counter: counting modes and one-shot FSM states.
package counter_pkg;

    typedef enum logic [1:0] {
        WRAP    = 2'b00,
        SAT     = 2'b01,
        MOD     = 2'b10,
        ONESHOT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } os_state_e;

endpackage

// File: rtl/counter_oneshot_fsm.sv
// One-shot control FSM: tracks IDLE/RUN/DONE and tells the datapath when to restart or step.
module counter_oneshot_fsm
    import counter_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      os_mode,
    input  logic      load,
    input  logic      start,
    input  logic      finish,
    output logic      run,
    output logic      done,
    output logic      restart,
    output os_state_e state_o
);

    os_state_e state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Kept apart from the next-state logic so the datapath can use it without a block-level loop.
    assign restart = os_mode && start && !load && (state_q != RUN);

    always_comb begin
        state_d = state_q;
        if (!os_mode || load) begin
            state_d = IDLE;
        end else if (restart) begin
            state_d = RUN;
        end else if ((state_q == RUN) && finish) begin
            state_d = DONE;
        end
    end

    assign run     = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign state_o = state_q;

endmodule

// File: rtl/counter_modal.sv
// Up/down counter with wrap, saturate, modulo and one-shot modes, sticky overflow and tc pulse.
module counter_modal
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] max_val,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    mode_e            mode_s;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             ovf_set;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] os_target;
    logic             os_at;
    logic             os_run, os_done, os_restart, os_finish;
    os_state_e        os_state;
    logic             os_unused;

    assign mode_s    = mode_e'(mode);
    assign stepped   = up_dn ? (count_q + ONE) : (count_q - ONE);
    assign os_target = up_dn ? max_val : '0;
    // Up counting treats count above max_val (after a max_val change) as already finished.
    assign os_at     = up_dn ? (count_q >= max_val) : (count_q == '0);
    assign os_finish = en && os_run && (os_at || (stepped == os_target));

    counter_oneshot_fsm u_fsm (
        .clk     (clk),
        .rst     (rst),
        .os_mode (mode_s == ONESHOT),
        .load    (load),
        .start   (start),
        .finish  (os_finish),
        .run     (os_run),
        .done    (os_done),
        .restart (os_restart),
        .state_o (os_state)
    );

    assign os_unused = os_done;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_set = 1'b0;
        if (load) begin
            count_d = ((mode_s == MOD) && (load_val > max_val)) ? max_val : load_val;
        end else if (os_restart) begin
            count_d = up_dn ? '0 : max_val;
        end else if (en) begin
            case (mode_s)
                WRAP: begin
                    count_d = stepped;
                    if (up_dn ? (count_q == ALL_ONES) : (count_q == '0)) begin
                        tc_d    = 1'b1;
                        ovf_set = 1'b1;
                    end
                end
                SAT: begin
                    if (up_dn ? (count_q == ALL_ONES) : (count_q == '0)) begin
                        ovf_set = 1'b1;
                    end else begin
                        count_d = stepped;
                        tc_d    = up_dn ? (stepped == ALL_ONES) : (stepped == '0);
                    end
                end
                MOD: begin
                    if (up_dn ? (count_q >= max_val) : (count_q == '0)) begin
                        count_d = up_dn ? '0 : max_val;
                        tc_d    = 1'b1;
                        ovf_set = 1'b1;
                    end else begin
                        count_d = stepped;
                    end
                end
                ONESHOT: begin
                    if (os_run) begin
                        if (!os_at) begin
                            count_d = stepped;
                        end
                        tc_d = os_finish;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
        // A set on the same edge as a clear wins.
        ovf_d = ovf_set | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
    assign busy  = (os_state == RUN);

endmodule

// File: tb/tb_counter_modal.sv
// Directed bench for counter_modal (WIDTH=4); observed vector is {count, tc, ovf, busy}.
module tb_counter_modal;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [3:0] max_val = 4'd0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       start = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [3:0] count;
    logic       tc, ovf, busy;

    logic [6:0] obs;
    logic [6:0] exp_v;
    int         checks = 0;
    int         errors = 0;

    assign obs = {count, tc, ovf, busy};

    counter_modal #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .mode     (mode),
        .max_val  (max_val),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .clr_ovf  (clr_ovf),
        .count    (count),
        .tc       (tc),
        .ovf      (ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock and land 1ns after the rising edge, where inputs change and outputs are sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        exp_v = {4'd0, 1'b0, 1'b0, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_async: got %b exp %b (count_tc_ovf_busy)", obs, exp_v); end
        step(); step();
        rst = 1'b0;
        step();
        exp_v = {4'd0, 1'b0, 1'b0, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_release_hold: got %b exp %b", obs, exp_v); end
    endtask

    task automatic test_wrap();
        mode = 2'b00; up_dn = 1'b1; load = 1'b1; load_val = 4'd13;
        step();
        load = 1'b0; en = 1'b1;
        step(); step();
        exp_v = {4'd15, 1'b0, 1'b0, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL wrap_up_15: got %b exp %b", obs, exp_v); end
        step();
        exp_v = {4'd0, 1'b1, 1'b1, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL wrap_up_to_0: got %b exp %b", obs, exp_v); end
        step();
        exp_v = {4'd1, 1'b0, 1'b1, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL wrap_tc_pulse_ovf_sticky: got %b exp %b", obs, exp_v); end
        en = 1'b0; clr_ovf = 1'b1;
        step();
        exp_v = {4'd1, 1'b0, 1'b0, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL wrap_clr_ovf_hold: got %b exp %b", obs, exp_v); end
        clr_ovf = 1'b0; up_dn = 1'b0; en = 1'b1;
        step(); step();
        exp_v = {4'd15, 1'b1, 1'b1, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL wrap_down_to_15: got %b exp %b", obs, exp_v); end
        en = 1'b0; clr_ovf = 1'b1; load = 1'b1; load_val = 4'd0;
        step();
        load = 1'b0; en = 1'b1;
        step();
        exp_v = {4'd15, 1'b1, 1'b1, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL wrap_set_beats_clear: got %b exp %b", obs, exp_v); end
        clr_ovf = 1'b0; en = 1'b0;
    endtask

    task automatic test_saturate();
        mode = 2'b01; up_dn = 1'b0; load = 1'b1; load_val = 4'd2; clr_ovf = 1'b1;
        step();
        load = 1'b0; clr_ovf = 1'b0; en = 1'b1;
        step();
        exp_v = {4'd1, 1'b0, 1'b0, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL sat_down_1: got %b exp %b", obs, exp_v); end
        step();
        exp_v = {4'd0, 1'b1, 1'b0, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL sat_down_reach_0: got %b exp %b", obs, exp_v); end
        step();
        exp_v = {4'd0, 1'b0, 1'b1, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL sat_down_blocked: got %b exp %b", obs, exp_v); end
        step();
        exp_v = {4'd0, 1'b0, 1'b1, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL sat_down_hold: got %b exp %b", obs, exp_v); end
        en = 1'b0; load = 1'b1; load_val = 4'd14; clr_ovf = 1'b1; up_dn = 1'b1;
        step();
        load = 1'b0; clr_ovf = 1'b0; en = 1'b1;
        step();
        exp_v = {4'd15, 1'b1, 1'b0, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL sat_up_reach_15: got %b exp %b", obs, exp_v); end
        step();
        exp_v = {4'd15, 1'b0, 1'b1, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL sat_up_blocked: got %b exp %b", obs, exp_v); end
        en = 1'b0;
    endtask

    task automatic test_modulo();
        mode = 2'b10; max_val = 4'd9; up_dn = 1'b1; load = 1'b1; load_val = 4'd0; clr_ovf = 1'b1;
        step();
        load = 1'b0; clr_ovf = 1'b0; en = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            exp_v = {4'(i), 1'b0, 1'b0, 1'b0}; checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL mod_up_step%0d: got %b exp %b", i, obs, exp_v); end
        end
        step();
        exp_v = {4'd0, 1'b1, 1'b1, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mod_up_9_to_0: got %b exp %b", obs, exp_v); end
        en = 1'b0; load = 1'b1; load_val = 4'd12; clr_ovf = 1'b1;
        step();
        exp_v = {4'd9, 1'b0, 1'b0, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mod_load_clamp: got %b exp %b", obs, exp_v); end
        load_val = 4'd0;
        step();
        load = 1'b0; clr_ovf = 1'b0; up_dn = 1'b0; en = 1'b1;
        step();
        exp_v = {4'd9, 1'b1, 1'b1, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mod_down_0_to_9: got %b exp %b", obs, exp_v); end
        step();
        exp_v = {4'd8, 1'b0, 1'b1, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mod_down_8: got %b exp %b", obs, exp_v); end
        en = 1'b0; mode = 2'b00; load = 1'b1; load_val = 4'd14; clr_ovf = 1'b1;
        step();
        load = 1'b0; clr_ovf = 1'b0; mode = 2'b10; up_dn = 1'b1; en = 1'b1;
        step();
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL mod_above_max_to_0: got count %0d exp 0", count); end
        en = 1'b0; max_val = 4'd0; load = 1'b1; load_val = 4'd0;
        step();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({count, tc} !== {4'd0, 1'b1}) begin errors++; $display("FAIL mod_max0_cycle%0d: got count %0d tc %b exp 0 1", i, count, tc); end
        end
        en = 1'b0; clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
    endtask

    task automatic test_oneshot();
        mode = 2'b11; max_val = 4'd5; up_dn = 1'b1; en = 1'b1; start = 1'b1;
        step();
        exp_v = {4'd0, 1'b0, 1'b0, 1'b1}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL os_start: got %b exp %b", obs, exp_v); end
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            exp_v = {4'(i), 1'b0, 1'b0, 1'b1}; checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL os_run_step%0d: got %b exp %b", i, obs, exp_v); end
        end
        step();
        exp_v = {4'd5, 1'b1, 1'b0, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL os_reach_5: got %b exp %b", obs, exp_v); end
        step();
        exp_v = {4'd5, 1'b0, 1'b0, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL os_done_hold: got %b exp %b", obs, exp_v); end
        start = 1'b1;
        step();
        exp_v = {4'd0, 1'b0, 1'b0, 1'b1}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL os_restart: got %b exp %b", obs, exp_v); end
        step();
        exp_v = {4'd1, 1'b0, 1'b0, 1'b1}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL os_start_ignored_in_run: got %b exp %b", obs, exp_v); end
        start = 1'b0;
    endtask

    task automatic test_async_reset();
        step();
        exp_v = {4'd2, 1'b0, 1'b0, 1'b1}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rst_pre_run: got %b exp %b", obs, exp_v); end
        #3;
        rst = 1'b1;
        #1;
        exp_v = {4'd0, 1'b0, 1'b0, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rst_mid_run_immediate: got %b exp %b", obs, exp_v); end
        step();
        rst = 1'b0;
        step();
        exp_v = {4'd0, 1'b0, 1'b0, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rst_release_idle: got %b exp %b", obs, exp_v); end
    endtask

    task automatic test_load_priority();
        mode = 2'b00; up_dn = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd7;
        step();
        exp_v = {4'd7, 1'b0, 1'b0, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL load_beats_en: got %b exp %b", obs, exp_v); end
        load = 1'b0; en = 1'b0; mode = 2'b11; max_val = 4'd5; start = 1'b1;
        step();
        start = 1'b0; load = 1'b1; load_val = 4'd3;
        step();
        exp_v = {4'd3, 1'b0, 1'b0, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL load_aborts_run: got %b exp %b", obs, exp_v); end
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0; mode = 2'b00;
        step();
        exp_v = {4'd0, 1'b0, 1'b0, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mode_change_forces_idle: got %b exp %b", obs, exp_v); end
        start = 1'b1;
        step();
        exp_v = {4'd0, 1'b0, 1'b0, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL start_ignored_non_oneshot: got %b exp %b", obs, exp_v); end
        mode = 2'b11; up_dn = 1'b0; max_val = 4'd2;
        step();
        start = 1'b0; en = 1'b1;
        step();
        exp_v = {4'd1, 1'b0, 1'b0, 1'b1}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL os_down_1: got %b exp %b", obs, exp_v); end
        step();
        exp_v = {4'd0, 1'b1, 1'b0, 1'b0}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL os_down_reach_0: got %b exp %b", obs, exp_v); end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_saturate();
        test_modulo();
        test_oneshot();
        test_async_reset();
        test_load_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_modal.md
COUNTER_MODAL -- requirements
Module: counter_modal

Interface
REQ-001 The module SHALL use a single clock `clk` and an asynchronous, active-high reset `rst`; no other clock or reset exists.
REQ-002 Parameter: WIDTH, default 4, counter width in bits, legal range 2..32.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: rst  in  1  asynchronous active-high reset.
REQ-005 Port: en  in  1  count enable; one step per cycle while high.
REQ-006 Port: up_dn  in  1  direction; 1 = up, 0 = down.
REQ-007 Port: mode  in  2  00 wrap, 01 saturate, 10 modulo, 11 one-shot.
REQ-008 Port: max_val  in  WIDTH  modulo/one-shot limit.
REQ-009 Port: load  in  1  synchronous load strobe.
REQ-010 Port: load_val  in  WIDTH  value to load.
REQ-011 Port: start  in  1  one-shot trigger.
REQ-012 Port: clr_ovf  in  1  clears the sticky overflow flag.
REQ-013 Port: count  out  WIDTH  registered count value.
REQ-014 Port: tc  out  1  registered terminal-count pulse, one cycle.
REQ-015 Port: ovf  out  1  sticky overflow/wrap flag.
REQ-016 Port: busy  out  1  high while the one-shot is in RUN.

Function
REQ-017 Priority per edge SHALL be: rst > load > start > en; with en low and no load/start, count SHALL hold.
REQ-018 load SHALL set count = load_val, or max_val if mode = 10 and load_val > max_val; tc = 0 that cycle; the one-shot FSM SHALL go to IDLE.
REQ-019 Wrap (00): up all-ones -> 0, down 0 -> all-ones; tc = 1 and ovf set on the wrapping edge.
REQ-020 Saturate (01): up holds at all-ones, down holds at 0; tc = 1 on the edge count reaches the bound; ovf set when an enabled step is blocked at the bound.
REQ-021 Modulo (10): up max_val -> 0, down 0 -> max_val; tc = 1 and ovf set on that edge; if count > max_val (after a mode change), the next up step SHALL go to 0.
REQ-022 Modulo with max_val = 0 SHALL hold count at 0 with tc = 1 on every enabled cycle.
REQ-023 One-shot (11) FSM states SHALL be IDLE, RUN, DONE; IDLE --start--> RUN, with count = 0 (up) or max_val (down).
REQ-024 In RUN, each en cycle SHALL step count by one; on reaching max_val (up) or 0 (down), go to DONE with tc = 1 on that edge.
REQ-025 DONE SHALL hold count; start in DONE SHALL restart as in REQ-023; start in RUN SHALL be ignored.
REQ-026 busy SHALL equal (state == RUN); with mode != 11, the FSM SHALL be forced to IDLE on the next edge and start is ignored.
REQ-027 up_dn, mode and max_val changes SHALL take effect on the next edge without glitching count.
REQ-028 ovf SHALL stay high until a clr_ovf edge; if set and clear happen on the same edge, set SHALL win.
REQ-029 All outputs SHALL be registered; latency from en to count change SHALL be one clock.

Reset
REQ-030 rst high SHALL immediately force count = 0, tc = 0, ovf = 0, busy = 0, FSM = IDLE, independent of clk.
REQ-031 Reset release SHALL be honoured at the next clk edge; mid-RUN reset SHALL abort to IDLE with no tc.

Structure
REQ-032 Package counter_pkg SHALL hold the mode_e enum (WRAP, SAT, MOD, ONESHOT) and the os_state_e enum (IDLE, RUN, DONE).
REQ-033 The one-shot FSM SHALL be a sub-module counter_oneshot_fsm, outputting run/done/restart controls; count datapath stays in counter_modal.

Verification
REQ-034 WIDTH=4, mode=00, up, en=1 from 0 -> count 15 then 0, tc = 1 on that edge, ovf = 1.
REQ-035 mode=01, down from 2, en=1 for 4 cycles -> count 1, 0, 0, 0; tc on the 0 edge; ovf set on the 3rd cycle.
REQ-036 mode=10, max_val=9, up -> 0..9, 0; tc at 9 -> 0; load_val=12 -> count 9.
REQ-037 mode=11, max_val=5, start, en=1 -> busy 5 cycles, count 0..5, tc at 5, DONE holds 5; start again -> count 0.
REQ-038 rst asserted mid-RUN between clock edges -> count, busy, tc = 0 immediately; load + en same cycle -> load_val wins.
